// File: rtl/libstf_pkg.sv
// Shared libstf package: address/size types, the host buffer descriptor,
// the transfer request record and the transfer_splitter FSM state type.
package libstf;

  localparam int unsigned VADDR_BITS          = 48;
  // Host allocations are at most 2^28-1 bytes, so sizes fit a 32-bit interrupt value.
  localparam int unsigned ALLOC_SIZE_BITS     = 28;
  localparam int unsigned TRANSFER_SIZE_BYTES = 4096;

  typedef logic [VADDR_BITS-1:0]      vaddress_t;
  typedef logic [ALLOC_SIZE_BITS-1:0] alloc_size_t;

  typedef struct packed {
    vaddress_t   vaddr;
    alloc_size_t size;
  } buffer_t;

  typedef struct packed {
    vaddress_t   vaddr;
    alloc_size_t len;
    logic        last;
  } transfer_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } splitter_state_t;

endpackage

// File: rtl/transfer_splitter.sv
// transfer_splitter: splits one host buffer descriptor into memory write
// requests of at most TRANSFER_SIZE bytes, limits unacknowledged requests to
// MAX_OUTSTANDING, and reports the buffer's total size once every request
// has been acknowledged.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   buf_valid/ready/data   buffer descriptor input (vaddr + size)
//   req_valid/ready        request handshake
//   req_vaddr/len/last     current request (registered)
//   ack_valid              one-cycle pulse per completed request
//   done_valid/ready/size  buffer completion (registered)
//   busy                   FSM not idle
//   err_ack                sticky: ack received with nothing outstanding
module transfer_splitter
  import libstf::*;
#(
  parameter int unsigned TRANSFER_SIZE   = TRANSFER_SIZE_BYTES,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        buf_valid,
  output logic        buf_ready,
  input  buffer_t     buf_data,
  output logic        req_valid,
  input  logic        req_ready,
  output vaddress_t   req_vaddr,
  output alloc_size_t req_len,
  output logic        req_last,
  input  logic        ack_valid,
  output logic        done_valid,
  input  logic        done_ready,
  output alloc_size_t done_size,
  output logic        busy,
  output logic        err_ack
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
  localparam alloc_size_t   TS    = alloc_size_t'(TRANSFER_SIZE);

  splitter_state_t state_q, state_d;
  transfer_req_t   req_q, req_d;       // req_q.vaddr doubles as the running address
  alloc_size_t     remaining_q, remaining_d;
  alloc_size_t     total_q, total_d;
  logic [OW-1:0]   out_q, out_d;
  logic            req_valid_q, req_valid_d;
  logic            done_valid_q, done_valid_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            live_q;             // holds buf_ready low while in reset

  logic buf_hs, req_hs, ack_ok;

  assign buf_ready  = live_q && (state_q == ST_IDLE);
  assign buf_hs     = buf_valid && buf_ready;
  assign req_hs     = req_valid_q && req_ready;
  assign ack_ok     = ack_valid && (out_q != '0);

  assign req_valid  = req_valid_q;
  assign req_vaddr  = req_q.vaddr;
  assign req_len    = req_q.len;
  assign req_last   = req_q.last;
  assign done_valid = done_valid_q;
  assign done_size  = total_q;
  assign busy       = busy_q;
  assign err_ack    = err_q;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    out_d       = out_q;
    err_d       = err_q;

    if (ack_valid && (out_q == '0)) err_d = 1'b1;

    if (req_hs && !ack_ok)      out_d = out_q + OW'(1);
    else if (!req_hs && ack_ok) out_d = out_q - OW'(1);

    case (state_q)
      ST_IDLE: begin
        if (buf_hs) begin
          req_d.vaddr = buf_data.vaddr;
          remaining_d = buf_data.size;
          total_d     = buf_data.size;
          out_d       = '0;
          state_d     = (buf_data.size == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_hs) begin
          req_d.vaddr = req_q.vaddr + vaddress_t'(req_q.len);
          remaining_d = remaining_q - req_q.len;
          if (req_q.last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Uses the post-ack count so done_valid follows the final ack by one cycle.
        if (out_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are computed from the next-state values.
    req_d.len    = (remaining_d > TS) ? TS : remaining_d;
    req_d.last   = (state_d == ST_ISSUE) && (remaining_d <= TS);
    req_valid_d  = (state_d == ST_ISSUE) && (out_d < MAX_O);
    done_valid_d = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      remaining_q  <= '0;
      total_q      <= '0;
      out_q        <= '0;
      req_valid_q  <= 1'b0;
      done_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      remaining_q  <= remaining_d;
      total_q      <= total_d;
      out_q        <= out_d;
      req_valid_q  <= req_valid_d;
      done_valid_q <= done_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      live_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_transfer_splitter.sv
module tb_transfer_splitter;
  import libstf::*;

  localparam int unsigned TS = 4096;
  localparam int unsigned MO = 2;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        buf_valid;
  logic        buf_ready;
  buffer_t     buf_data;
  logic        req_valid;
  logic        req_ready;
  vaddress_t   req_vaddr;
  alloc_size_t req_len;
  logic        req_last;
  logic        ack_valid;
  logic        done_valid;
  logic        done_ready;
  alloc_size_t done_size;
  logic        busy;
  logic        err_ack;

  transfer_splitter #(.TRANSFER_SIZE(TS), .MAX_OUTSTANDING(MO)) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .buf_valid(buf_valid), .buf_ready(buf_ready), .buf_data(buf_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_len(req_len), .req_last(req_last), .ack_valid(ack_valid),
    .done_valid(done_valid), .done_ready(done_ready), .done_size(done_size),
    .busy(busy), .err_ack(err_ack)
  );

  always #5 aclk = ~aclk;

  int unsigned checks = 0, passes = 0, fails = 0;
  int cyc = 0;
  int nm  = 0;
  transfer_req_t expq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    cyc++;
  endtask

  // Reference split: consecutive chunks of TS bytes, last one short, addresses mod 2^48.
  task automatic build(input vaddress_t va, input alloc_size_t sz);
    transfer_req_t t;
    longint off;
    expq.delete();
    off = 0;
    while (off < longint'(sz)) begin
      t.vaddr = vaddress_t'(longint'(va) + off);
      t.len   = (longint'(sz) - off > longint'(TS)) ? alloc_size_t'(TS) : alloc_size_t'(longint'(sz) - off);
      t.last  = (off + longint'(TS) >= longint'(sz));
      expq.push_back(t);
      off += longint'(TS);
    end
  endtask

  task automatic check_req();
    transfer_req_t e;
    if (expq.size() == 0) check("extra_req", 1, 0);
    else begin
      e = expq.pop_front();
      check("req_vaddr", req_vaddr, e.vaddr);
      check("req_len", req_len, e.len);
      check("req_last", req_last, e.last);
    end
  endtask

  task automatic send_desc(input vaddress_t va, input alloc_size_t sz, output int hs);
    int w = 0;
    while (!buf_ready && w < 50) begin tick(); w++; end
    check("buf_ready_idle", buf_ready, 1);
    buf_valid = 1'b1;
    buf_data  = '{vaddr: va, size: sz};
    hs = cyc;
    tick();
    buf_valid = 1'b0;
  endtask

  // One directed cycle with req_ready=1; counts/checks any handshake seen.
  task automatic cycle(input bit ack);
    ack_valid = ack;
    if (req_valid && req_ready) begin check_req(); nm++; end
    tick();
  endtask

  task automatic run_buffer(input vaddress_t va, input alloc_size_t sz, input int delay,
                            input bit rnd, input bit err_exp);
    int hs, last_ack, nreq, ncount;
    int ackq[$];
    bit done, seen, stall;
    transfer_req_t prev;
    nreq = 0; last_ack = 0; done = 0; seen = 0; stall = 0;
    build(va, sz);
    ncount = expq.size();
    send_desc(va, sz, hs);
    for (int i = 0; i < 3000 && !done; i++) begin
      if (req_valid && !seen) begin
        seen = 1;
        check("first_req_latency", cyc, hs + 1);
      end
      if (stall) begin
        check("stall_valid", req_valid, 1);
        check("stall_vaddr", req_vaddr, prev.vaddr);
        check("stall_len", req_len, prev.len);
        check("stall_last", req_last, prev.last);
      end
      if (done_valid) begin
        check("done_size", done_size, sz);
        check("req_count", nreq, ncount);
        check("done_latency", cyc, (sz == 0) ? hs + 1 : last_ack + 1);
        check("busy_done", busy, 1);
        check("err_ack_level", err_ack, err_exp);
        ack_valid  = 1'b0;
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("idle_after_done", buf_ready, 1);
        check("busy_idle", busy, 0);
        done = 1;
      end else begin
        ack_valid = 1'b0;
        if (ackq.size() > 0 && ackq[0] == cyc) begin
          void'(ackq.pop_front());
          ack_valid = 1'b1;
          last_ack  = cyc;
        end
        req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        stall = req_valid && !req_ready;
        prev  = '{vaddr: req_vaddr, len: req_len, last: req_last};
        if (req_valid && req_ready) begin
          check_req();
          nreq++;
          ackq.push_back(cyc + delay);
        end
        tick();
      end
    end
    ack_valid = 1'b0;
    req_ready = 1'b1;
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_buf_ready"}, buf_ready, 0);
    check({tag, "_req_valid"}, req_valid, 0);
    check({tag, "_req_last"}, req_last, 0);
    check({tag, "_done_valid"}, done_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_ack"}, err_ack, 0);
    check({tag, "_req_vaddr"}, req_vaddr, 0);
    check({tag, "_req_len"}, req_len, 0);
    check({tag, "_done_size"}, done_size, 0);
  endtask

  initial begin
    int hs;
    aresetn = 1'b0; buf_valid = 1'b0; buf_data = '0; req_ready = 1'b1;
    ack_valid = 1'b0; done_ready = 1'b0;

    // Reset values
    repeat (2) tick();
    check_reset_outputs("rst");
    aresetn = 1'b1;
    tick();
    check("buf_ready_post_rst", buf_ready, 1);

    // Short final transfer, zero size, exact multiple
    run_buffer(48'h1000, 28'd10000, 3, 0, 0);
    run_buffer(48'h2_0000, 28'd0, 3, 0, 0);
    run_buffer(48'h8000, 28'd8192, 3, 0, 0);

    // Outstanding limit and coincident ack/handshake
    build(48'h0, 28'd20480);
    nm = 0;
    req_ready = 1'b1;
    send_desc(48'h0, 28'd20480, hs);
    repeat (6) cycle(0);
    check("limit_count", nm, 2);
    check("limit_valid_low", req_valid, 0);
    cycle(1);
    check("limit_release", req_valid, 1);
    repeat (3) cycle(0);
    check("limit_one_more", nm, 3);
    check("limit_valid_low2", req_valid, 0);
    cycle(1);
    check("limit_release2", req_valid, 1);
    cycle(1);
    check("coincident_valid", req_valid, 1);
    cycle(0);
    check("limit_all_reqs", nm, 5);
    check("limit_model_empty", expq.size(), 0);
    cycle(1);
    check("limit_not_done", done_valid, 0);
    cycle(1);
    check("limit_done", done_valid, 1);
    check("limit_done_size", done_size, 20480);
    ack_valid  = 1'b0;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;

    // Randomized backpressure, lengths, addresses and ack delays; one wraps the address
    run_buffer(48'hFFFF_FFFF_F000, 28'd10000, 2, 1, 0);
    repeat (6) begin
      vaddress_t va;
      va = vaddress_t'({$urandom, $urandom});
      run_buffer(va, alloc_size_t'($urandom_range(1, 5 * TS + 100)), $urandom_range(1, 5), 1, 0);
    end

    // Stray ack in IDLE
    check("err_ack_before", err_ack, 0);
    ack_valid = 1'b1;
    tick();
    ack_valid = 1'b0;
    tick();
    check("err_ack_set", err_ack, 1);
    run_buffer(48'h3000, 28'd5000, 2, 1, 1);
    check("err_ack_sticky", err_ack, 1);

    // Reset mid-operation
    build(48'h5000, 28'd16384);
    nm = 0;
    send_desc(48'h5000, 28'd16384, hs);
    cycle(0);
    cycle(0);
    check("pre_rst_reqs", nm, 2);
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    aresetn = 1'b1;
    tick();
    check("buf_ready_after_midrst", buf_ready, 1);
    run_buffer(48'h7000, 28'd5000, 2, 1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
